cpu16_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 16-bit CPU datapath. It fetches each 16-bit instruction as two bytes from the byte-wide program memory and latches it into IR. It then drives register-file read addresses and ALU function selects, and commits the ALU result back to the register file. It sits between the program memory, the 16×16 register file and the ALU, and replaces free-running, testbench-driven sequencing of those resources.

---
 rtl/cpu16_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cpu16_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu16_seq_ctrl.sv
// cpu16_seq_ctrl: multi-cycle fetch/exec/writeback sequencer for the 16-bit CPU.
// Define CPU16_SEQ_HALT_EN to decode opcode 000 with IR[4]=1 as HALT.
module cpu16_seq_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        CK,
    input  logic        RST_N,
    input  logic        run,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic        rf_we,
    input  logic        alu_cout,
    output logic        S_SUB,
    output logic        S_FAS,
    output logic        IsAND,
    output logic        IsOR,
    output logic        IsXOR,
    output logic        IsNOT,
    output logic [7:0]  PC,
    output logic [15:0] IR,
    output logic        C,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [7:0]  addr_q;
    logic [15:0] ir_q;
    logic        c_q;
    logic        req_q;
    logic        we_q;
    logic [5:0]  sel_q;

    logic [7:0]  pc_inc_d;
    logic [7:0]  pc_next_d;
    logic        is_arith_d;
    logic        is_halt_d;

    // Select vector order: {S_SUB, S_FAS, IsAND, IsOR, IsXOR, IsNOT}
    function automatic logic [5:0] dec_sel(input logic [2:0] op);
        logic [5:0] s;
        case (op)
            OP_SUB:  s = 6'b110000;
            OP_ADD:  s = 6'b010000;
            OP_AND:  s = 6'b001000;
            OP_OR:   s = 6'b000100;
            OP_XOR:  s = 6'b000010;
            OP_NOT:  s = 6'b000001;
            OP_MOV:  s = 6'b000000;
            default: s = 6'b000000;
        endcase
        return s;
    endfunction

    assign pc_inc_d   = pc_q + 8'd1;
    assign pc_next_d  = pc_q + 8'd2;
    assign is_arith_d = (ir_q[7:5] == OP_ADD) || (ir_q[7:5] == OP_SUB);

`ifdef CPU16_SEQ_HALT_EN
    assign is_halt_d = (ir_q[7:5] == OP_NOP) && ir_q[4];
    assign halted    = (state_q == ST_HALT);
`else
    assign is_halt_d = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= 16'h0000;
            c_q     <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 6'b000000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH0;
                    end
                end
                ST_FETCH0: begin
                    if (mem_ack) begin
                        ir_q[15:8] <= mem_rdata;
                        addr_q     <= pc_inc_d;
                        state_q    <= ST_FETCH1;
                    end
                end
                ST_FETCH1: begin
                    if (mem_ack) begin
                        ir_q[7:0] <= mem_rdata;
                        addr_q    <= pc_q;
                        req_q     <= 1'b0;
                        sel_q     <= dec_sel(mem_rdata[7:5]);
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    we_q    <= (ir_q[7:5] != OP_NOP);
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    we_q  <= 1'b0;
                    sel_q <= 6'b000000;
                    if (is_arith_d) begin
                        c_q <= alu_cout;
                    end
                    if (is_halt_d) begin
                        state_q <= ST_HALT;
                    end else begin
                        pc_q    <= pc_next_d;
                        addr_q  <= pc_next_d;
                        req_q   <= run;
                        state_q <= run ? ST_FETCH0 : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign rf_ra    = ir_q[11:8];
    assign rf_rb    = ir_q[3:0];
    assign rf_we    = we_q;
    assign S_SUB    = sel_q[5];
    assign S_FAS    = sel_q[4];
    assign IsAND    = sel_q[3];
    assign IsOR     = sel_q[2];
    assign IsXOR    = sel_q[1];
    assign IsNOT    = sel_q[0];
    assign PC       = pc_q;
    assign IR       = ir_q;
    assign C        = c_q;

endmodule

// File: tb/tb_cpu16_seq_ctrl.sv
// tb_cpu16_seq_ctrl: random program run against an instruction-level model,
// with a byte memory, register file and ALU around the sequencer.
module tb_cpu16_seq_ctrl;

`ifdef CPU16_SEQ_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif
    localparam logic [7:0] RstPc = 8'h00;

    logic        CK = 1'b0;
    logic        RST_N;
    logic        run;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  rf_ra;
    logic [3:0]  rf_rb;
    logic        rf_we;
    logic        alu_cout;
    logic        S_SUB;
    logic        S_FAS;
    logic        IsAND;
    logic        IsOR;
    logic        IsXOR;
    logic        IsNOT;
    logic [7:0]  PC;
    logic [15:0] IR;
    logic        C;
    logic        halted;
    logic [5:0]  sel;

    always #5 CK = ~CK;

    cpu16_seq_ctrl #(.RESET_PC(RstPc)) dut (
        .CK        (CK),
        .RST_N     (RST_N),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_we     (rf_we),
        .alu_cout  (alu_cout),
        .S_SUB     (S_SUB),
        .S_FAS     (S_FAS),
        .IsAND     (IsAND),
        .IsOR      (IsOR),
        .IsXOR     (IsXOR),
        .IsNOT     (IsNOT),
        .PC        (PC),
        .IR        (IR),
        .C         (C),
        .halted    (halted)
    );

    assign sel = {S_SUB, S_FAS, IsAND, IsOR, IsXOR, IsNOT};

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [256];
    int          wait_tab [256];
    logic [15:0] rf [16];
    logic [15:0] m_rf [16];
    logic [7:0]  m_pc;
    logic        m_c;
    logic        m_halt;
    logic        pl_en;
    logic [3:0]  pl_a;
    logic [15:0] pl_d;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] alu_y;
    logic [16:0] sum;
    int          wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory: each byte address has its own number of wait cycles
    always @(negedge CK) begin
        if (mem_req) begin
            if (wcnt >= wait_tab[mem_addr]) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt      = wcnt + 1;
            end
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            wcnt      = 0;
        end
    end

    always_comb begin
        opa      = rf[rf_ra];
        opb      = rf[rf_rb];
        sum      = {1'b0, opa} + {1'b0, (S_SUB ? ~opb : opb)} + {16'd0, S_SUB};
        alu_cout = sum[16];
        if (S_FAS)      alu_y = sum[15:0];
        else if (IsAND) alu_y = opa & opb;
        else if (IsOR)  alu_y = opa | opb;
        else if (IsXOR) alu_y = opa ^ opb;
        else if (IsNOT) alu_y = ~opb;
        else            alu_y = opb;
    end

    always @(posedge CK) begin
        if (pl_en)      rf[pl_a] <= pl_d;
        else if (rf_we) rf[rf_ra] <= alu_y;
    end

    task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(posedge CK);
        #1;
        pl_en = 1'b0;
    endtask

    // Entered just after the edge that starts FETCH0; leaves just after
    // the edge that ends WB.
    task automatic step_instr(input bit drop_run);
        logic [7:0]  pc0;
        logic [7:0]  pc1;
        logic [15:0] ir;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [16:0] s;
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [5:0]  xsel;
        logic        c;
        logic        hlt;
        pc0  = m_pc;
        pc1  = pc0 + 8'd1;
        ir   = {mem[pc0], mem[pc1]};
        op   = ir[7:5];
        rd   = ir[11:8];
        hlt  = HaltEn && (op == 3'b000) && ir[4];
        a    = m_rf[rd];
        b    = m_rf[ir[3:0]];
        r    = a;
        c    = m_c;
        xsel = 6'b000000;
        case (op)
            3'b001: begin xsel = 6'b110000; r = a - b; c = (a >= b); end
            3'b010: begin xsel = 6'b000010; r = a ^ b; end
            3'b011: begin xsel = 6'b000001; r = ~b; end
            3'b100: begin r = b; end
            3'b101: begin
                xsel = 6'b010000;
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
            end
            3'b110: begin xsel = 6'b001000; r = a & b; end
            3'b111: begin xsel = 6'b000100; r = a | b; end
            default: ;
        endcase
        for (int i = 0; i <= wait_tab[pc0]; i++) begin
            @(negedge CK);
            if (drop_run) run = 1'b0;
            chk("f0_req", 32'(mem_req), 32'd1);
            chk("f0_addr", 32'(mem_addr), 32'(pc0));
        end
        for (int i = 0; i <= wait_tab[pc1]; i++) begin
            @(negedge CK);
            chk("f1_req", 32'(mem_req), 32'd1);
            chk("f1_addr", 32'(mem_addr), 32'(pc1));
            chk("f1_we", 32'(rf_we), 32'd0);
        end
        @(negedge CK);
        chk("ex_req", 32'(mem_req), 32'd0);
        chk("ex_we", 32'(rf_we), 32'd0);
        chk("ex_sel", 32'(sel), 32'(xsel));
        chk("ex_ir", 32'(IR), 32'(ir));
        chk("ex_ra", 32'(rf_ra), 32'(rd));
        chk("ex_rb", 32'(rf_rb), 32'(ir[3:0]));
        @(negedge CK);
        chk("wb_we", 32'(rf_we), 32'(op != 3'b000));
        chk("wb_sel", 32'(sel), 32'(xsel));
        chk("wb_req", 32'(mem_req), 32'd0);
        @(posedge CK);
        #1;
        if (op != 3'b000) m_rf[rd] = r;
        m_c    = c;
        m_halt = hlt;
        if (!hlt) m_pc = pc0 + 8'd2;
        chk("pc", 32'(PC), 32'(m_pc));
        chk("c", 32'(C), 32'(m_c));
        chk("rd", 32'(rf[rd]), 32'(m_rf[rd]));
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    initial begin
        RST_N  = 1'b0;
        run    = 1'b0;
        pl_en  = 1'b0;
        pl_a   = 4'd0;
        pl_d   = 16'd0;
        m_halt = 1'b0;
        for (int i = 0; i < 256; i += 2) begin
            mem[i]          = 8'($urandom);
            mem[i + 1]      = 8'($urandom);
            wait_tab[i]     = $urandom_range(0, 2);
            wait_tab[i + 1] = $urandom_range(0, 2);
            if (HaltEn && mem[i + 1][7:5] == 3'b000) mem[i + 1][4] = 1'b0;
        end
        mem[0]   = 8'h00; mem[1]   = 8'hA1;
        mem[2]   = 8'h02; mem[3]   = 8'h23;
        mem[254] = 8'h00; mem[255] = 8'h00;
        wait_tab[0] = 0; wait_tab[1] = 0;
        wait_tab[2] = 0; wait_tab[3] = 0;
        wait_tab[4] = 3; wait_tab[5] = 3;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'($urandom);
        m_rf[0] = 16'hFF00;
        m_rf[1] = 16'h0101;
        m_rf[2] = 16'd16;
        m_rf[3] = 16'd9;
        for (int i = 0; i < 16; i++) set_reg(4'(i), m_rf[i]);
        m_pc = RstPc;
        m_c  = 1'b0;

        @(negedge CK);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(RstPc));
        chk("rst_pc", 32'(PC), 32'(RstPc));
        chk("rst_ir", 32'(IR), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        RST_N = 1'b1;
        @(negedge CK);
        chk("idle_req", 32'(mem_req), 32'd0);
        run = 1'b1;
        @(posedge CK);
        #1;
        for (int k = 0; k < 130; k++) step_instr(k == 129);
        repeat (3) begin
            @(negedge CK);
            chk("stop_req", 32'(mem_req), 32'd0);
            chk("stop_pc", 32'(PC), 32'(m_pc));
        end

        // Reset pulse in the middle of FETCH1
        run = 1'b1;
        @(posedge CK);
        #1;
        repeat (wait_tab[m_pc]) @(posedge CK);
        @(posedge CK);
        @(negedge CK);
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_addr", 32'(mem_addr), 32'(m_pc + 8'd1));
        RST_N = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_pc", 32'(PC), 32'(RstPc));
        chk("arst_ir", 32'(IR), 32'd0);
        chk("arst_c", 32'(C), 32'd0);
        repeat (2) @(negedge CK);
        for (int i = 0; i < 16; i++) chk("arst_rf", 32'(rf[i]), 32'(m_rf[i]));
        m_pc = RstPc;
        m_c  = 1'b0;

        // Opcode 000 with IR[4]=1: HALT when enabled, otherwise a NOP
        mem[0] = 8'h00;
        mem[1] = 8'h10;
        wait_tab[0] = 0;
        wait_tab[1] = 0;
        @(negedge CK);
        RST_N = 1'b1;
        run   = 1'b1;
        @(posedge CK);
        #1;
        step_instr(1'b1);
        repeat (4) begin
            @(negedge CK);
            chk("post_req", 32'(mem_req), 32'd0);
            chk("post_pc", 32'(PC), 32'(m_pc));
            chk("post_halted", 32'(halted), 32'(m_halt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
